// File: rtl/regseq_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the register-file op sequencer.
package regseq_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned OP_W       = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_MOV = 3'd1;
  localparam logic [OP_W-1:0] OP_LDI = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_AND = 3'd5;
  localparam logic [OP_W-1:0] OP_OR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer's EXEC step.
// Optional macro REGSEQ_SATURATE_EN clamps ADD overflow to all-ones and SUB borrow to zero.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  // One extra bit holds the carry out of ADD and the borrow out of SUB.
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
`ifdef REGSEQ_SATURATE_EN
        if (sum[DATA_W]) result = '1;
`endif
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
`ifdef REGSEQ_SATURATE_EN
        if (diff[DATA_W]) result = '0;
`endif
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle IDLE->READ->EXEC->WRITE controller running one ALU command against the register file.
// Build option REGSEQ_SATURATE_EN (see regseq_alu) selects saturating ADD/SUB.
module regfile_op_sequencer
  import regseq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_dest,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy
);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic                alu_zero;

  regseq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      dst_q          <= '0;
      imm_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      rf_read_addr_1 <= '0;
      rf_read_addr_2 <= '0;
      rf_write_en    <= 1'b0;
      rf_write_dest  <= '0;
      rf_write_data  <= '0;
      done           <= 1'b0;
      result         <= '0;
      zero_flag      <= 1'b0;
      carry_flag     <= 1'b0;
    end else begin
      rf_write_en <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q           <= cmd_op;
            dst_q          <= cmd_dst;
            imm_q          <= cmd_imm;
            rf_read_addr_1 <= cmd_src1;
            rf_read_addr_2 <= cmd_src2;
            state          <= ST_READ;
          end
        end
        ST_READ: begin
          opa_q <= rf_read_data_1;
          opb_q <= rf_read_data_2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // NOP leaves result and both flags untouched; carry only tracks ADD..XOR.
          if (op_q != OP_NOP) begin
            result    <= alu_result;
            zero_flag <= alu_zero;
          end
          if (op_q >= OP_ADD) carry_flag <= alu_carry;
          rf_write_en   <= (op_q != OP_NOP);
          rf_write_dest <= dst_q;
          rf_write_data <= (op_q == OP_NOP) ? result : alu_result;
          done          <= 1'b1;
          state         <= ST_WRITE;
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed self-checking bench for regfile_op_sequencer with a behavioural 8x8 register file.
module tb_regfile_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rf_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src1;
  logic [2:0] cmd_src2;
  logic [7:0] cmd_imm;
  logic [2:0] rf_read_addr_1;
  logic [2:0] rf_read_addr_2;
  logic [7:0] rf_read_data_1;
  logic [7:0] rf_read_data_2;
  logic       rf_write_en;
  logic [2:0] rf_write_dest;
  logic [7:0] rf_write_data;
  logic       done;
  logic [7:0] result;
  logic       zero_flag;
  logic       carry_flag;
  logic       busy;

  logic [7:0] rf [8];
  int         wr7_cnt;
  int         we_bad = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_dst        (cmd_dst),
    .cmd_src1       (cmd_src1),
    .cmd_src2       (cmd_src2),
    .cmd_imm        (cmd_imm),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .rf_write_en    (rf_write_en),
    .rf_write_dest  (rf_write_dest),
    .rf_write_data  (rf_write_data),
    .done           (done),
    .result         (result),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .busy           (busy)
  );

  // Register file model: reset values r0=1, r1=2, rest 0; own reset so sequencer resets don't wipe it.
  always @(posedge clk or negedge rf_rst_n) begin
    if (!rf_rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      rf[0]   <= 8'h01;
      rf[1]   <= 8'h02;
      wr7_cnt <= 0;
    end else if (rf_write_en) begin
      rf[rf_write_dest] <= rf_write_data;
      if (rf_write_dest == 3'd7) wr7_cnt <= wr7_cnt + 1;
    end
  end

  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];

  always @(negedge clk) if (rf_write_en && !done) we_bad++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge; returns at the negedge where done is seen.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] imm,
                         output int lat, output int we_cnt);
    int n;
    lat    = 0;
    we_cnt = 0;
    cmd_op = op; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      if (rf_write_en) we_cnt++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic exec_check(input string tag, input logic [2:0] op, input logic [2:0] d,
                            input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] imm,
                            input logic [7:0] exp_data, input logic exp_we,
                            input logic exp_zero, input logic exp_carry);
    int lat;
    int wec;
    run_cmd(op, d, s1, s2, imm, lat, wec);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_we"}, 32'(wec), 32'(exp_we));
    if (exp_we) check({tag, "_dest"}, 32'(rf_write_dest), 32'(d));
    check({tag, "_data"}, 32'(rf_write_data), 32'(exp_data));
    check({tag, "_result"}, 32'(result), 32'(exp_data));
    check({tag, "_zero"}, 32'(zero_flag), 32'(exp_zero));
    check({tag, "_carry"}, 32'(carry_flag), 32'(exp_carry));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (exp_we) check({tag, "_rf"}, 32'(rf[d]), 32'(exp_data));
  endtask

  logic [7:0] exp_r5;
  logic [2:0] b2b_op  [3];
  logic [2:0] b2b_dst [3];
  logic [2:0] b2b_s1  [3];
  logic [2:0] b2b_s2  [3];
  logic [7:0] b2b_imm [3];
  int         acc_cyc [3];
  int         n_acc;
  int         ready_bad;
  int         wait_cnt;

  initial begin
`ifdef REGSEQ_SATURATE_EN
    exp_r5 = 8'hFF;
`else
    exp_r5 = 8'h10;
`endif
    rst_n = 1'b0; rf_rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src1 = 3'd0; cmd_src2 = 3'd0; cmd_imm = 8'h00;
    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_write_en), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({zero_flag, carry_flag}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rf_rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    exec_check("add_r2", 3'd3, 3'd2, 3'd0, 3'd1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    exec_check("ldi_r3", 3'd2, 3'd3, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b1, 1'b0, 1'b0);
    exec_check("ldi_r4", 3'd2, 3'd4, 3'd0, 3'd0, 8'h20, 8'h20, 1'b1, 1'b0, 1'b0);
    exec_check("add_ovf", 3'd3, 3'd5, 3'd3, 3'd4, 8'h00, exp_r5, 1'b1, 1'b0, 1'b1);
    exec_check("sub_brw", 3'd4, 3'd6, 3'd0, 3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    exec_check("xor_self", 3'd7, 3'd6, 3'd6, 3'd6, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // Back-to-back with cmd_valid held high: LDI r3=0F, LDI r4=3C, AND r5=r3&r4.
    b2b_op[0] = 3'd2; b2b_dst[0] = 3'd3; b2b_s1[0] = 3'd0; b2b_s2[0] = 3'd0; b2b_imm[0] = 8'h0F;
    b2b_op[1] = 3'd2; b2b_dst[1] = 3'd4; b2b_s1[1] = 3'd0; b2b_s2[1] = 3'd0; b2b_imm[1] = 8'h3C;
    b2b_op[2] = 3'd5; b2b_dst[2] = 3'd5; b2b_s1[2] = 3'd3; b2b_s2[2] = 3'd4; b2b_imm[2] = 8'h00;
    for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
    n_acc = 0; ready_bad = 0;
    cmd_op = b2b_op[0]; cmd_dst = b2b_dst[0]; cmd_src1 = b2b_s1[0];
    cmd_src2 = b2b_s2[0]; cmd_imm = b2b_imm[0];
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 24 && n_acc < 3; cyc++) begin
      if (cmd_ready == busy) ready_bad++;
      if (cmd_valid && cmd_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        @(posedge clk);
        @(negedge clk);
        if (n_acc < 3) begin
          cmd_op = b2b_op[n_acc]; cmd_dst = b2b_dst[n_acc]; cmd_src1 = b2b_s1[n_acc];
          cmd_src2 = b2b_s2[n_acc]; cmd_imm = b2b_imm[n_acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    wait_cnt = 0;
    while (!done && wait_cnt < 10) begin
      if (cmd_ready == busy) ready_bad++;
      @(negedge clk);
      wait_cnt++;
    end
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check("b2b_ready_vs_busy", 32'(ready_bad), 32'd0);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_and_data", 32'(rf_write_data), 32'h0C);
    check("b2b_and_carry", 32'(carry_flag), 32'd0);
    @(negedge clk);
    check("b2b_rf4", 32'(rf[4]), 32'h3C);
    check("b2b_rf5", 32'(rf[5]), 32'h0C);

    // Abort ADD r7 with reset while in EXEC.
    cmd_op = 3'd3; cmd_dst = 3'd7; cmd_src1 = 3'd0; cmd_src2 = 3'd1; cmd_imm = 8'h00;
    cmd_valid = 1'b1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_raddr", 32'({rf_read_addr_1, rf_read_addr_2}), 32'({3'd0, 3'd1}));
    @(negedge clk);
    check("abort_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result0", 32'(result), 32'd0);
    check("abort_outs0", 32'({done, rf_write_en, zero_flag, carry_flag, busy}), 32'd0);
    check("abort_addr0", 32'({rf_read_addr_1, rf_read_addr_2, rf_write_dest}), 32'd0);
    check("abort_wdata0", 32'(rf_write_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_rf7", 32'(rf[7]), 32'd0);
    check("abort_wr7", 32'(wr7_cnt), 32'd0);

    // NOP keeps flags/result; MOV keeps carry.
    exec_check("sub_pre", 3'd4, 3'd6, 3'd0, 3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    exec_check("nop", 3'd0, 3'd3, 3'd0, 3'd0, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1);
    check("nop_rf3", 32'(rf[3]), 32'h0F);
    exec_check("mov_r2", 3'd1, 3'd2, 3'd1, 3'd0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1);

    check("we_outside_write", 32'(we_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle controller that executes one register-to-register ALU command at a time against the team's 8-entry x 8-bit register file.
- Drives the file's two combinational read ports and its single write port; accepts commands over a valid/ready handshake.
- Reports completion, result and flags. It sits between the instruction-fetch/decode logic and the register file, and is the only agent driving the file's write port.

Parameters:
- DATA_W, 8, register/datapath width
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode (see Behaviour)
- cmd_dst  in  ADDR_W  destination register
- cmd_src1  in  ADDR_W  source A register
- cmd_src2  in  ADDR_W  source B register
- cmd_imm  in  DATA_W  immediate for LDI
- rf_read_addr_1  out  ADDR_W  to register file read port 1
- rf_read_addr_2  out  ADDR_W  to register file read port 2
- rf_read_data_1  in  DATA_W  from register file read port 1 (combinational)
- rf_read_data_2  in  DATA_W  from register file read port 2 (combinational)
- rf_write_en  out  1  register file write enable
- rf_write_dest  out  ADDR_W  register file write address
- rf_write_data  out  DATA_W  register file write data
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  last computed result, held until next EXEC
- zero_flag  out  1  result == 0
- carry_flag  out  1  carry (ADD) / borrow (SUB)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all registered outputs 0 (rf_* outputs, done, result, flags). cmd_ready=1 once rst_n is high. Reset mid-command aborts it; no write occurs.
- Opcodes:
  - 0 NOP: no write; done still pulses.
  - 1 MOV: dst=src1.
  - 2 LDI: dst=imm.
  - 3 ADD: src1+src2.
  - 4 SUB: src1-src2.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: cmd_ready=1. On the edge where cmd_valid&cmd_ready, latch op/dst/src1/src2/imm and go to READ.
  - READ: rf_read_addr_1/2 = latched src1/src2 (held until the next accept). At the clock edge, capture rf_read_data_1/2 into operand registers. Go to EXEC.
  - EXEC: compute in DATA_W+1 bits. Register result, zero_flag and carry_flag. Go to WRITE.
  - WRITE: rf_write_en=1 for exactly this cycle (0 for NOP), rf_write_dest=dst, rf_write_data=result. done=1 this cycle. Go to IDLE.
- Latency: done asserts 3 cycles after the accept edge. Throughput is one command per 4 cycles. cmd_ready=0 in READ/EXEC/WRITE.
- Handshake: the requester holds cmd_* stable while cmd_valid=1 and cmd_ready=0. cmd_valid while busy is ignored, not queued.
- Flags:
  - zero_flag updates on opcodes 1-7.
  - carry_flag updates on ADD (bit DATA_W of the sum) and SUB (1 if src1<src2), is cleared on AND/OR/XOR, and holds on NOP/MOV/LDI.
- Arithmetic wraps modulo 2**DATA_W (see Optional Feature).
- dst equal to src1/src2 is legal: operands are captured before the write. A back-to-back command reads the value written by the previous command.
- rf_write_en is never asserted outside WRITE.

Optional Feature:
- Macro REGSEQ_SATURATE_EN.
- Defined: ADD with carry writes 8'hFF; SUB with borrow writes 8'h00. carry_flag still reports the overflow, and zero_flag reflects the saturated result.
- Undefined: modulo wrap, no saturation logic synthesized.

Decomposition:
- Package regseq_pkg:
  - opcode localparams OP_NOP..OP_XOR
  - FSM state encoding ST_IDLE/ST_READ/ST_EXEC/ST_WRITE (2 bits)
  - DATA_W/ADDR_W defaults
- Sub-module regseq_alu: combinational, inputs op/a/b/imm, outputs result/carry/zero, contains the REGSEQ_SATURATE_EN logic. Instantiated once in the EXEC path.

Test Plan:
- Reset check: bench instantiates the team's register file (reset values r0=1, r1=2). Release rst_n, then ADD dst=2 src1=0 src2=1 -> done 3 cycles after accept, rf_write_en one cycle at dest 2 data 8'h03, zero=0, carry=0.
- LDI r3=8'hF0, then LDI r4=8'h20, then ADD r5=r3+r4 -> r5=8'h10 with carry=1. With REGSEQ_SATURATE_EN, r5=8'hFF with carry=1.
- SUB r6=r0-r1 (1-2) -> 8'hFF, carry(borrow)=1. Then XOR r6=r6^r6 -> 8'h00, zero=1, carry=0.
- Hold cmd_valid high continuously with 3 queued commands -> exactly one accept per 4 cycles, cmd_ready low in READ/EXEC/WRITE, no rf_write_en outside WRITE.
- Assert rst_n low during EXEC of ADD r7 -> no write to r7, all outputs 0 immediately, cmd_ready=1 after release.
- NOP and MOV r2=r1: NOP -> done pulse with rf_write_en=0 and flags unchanged. MOV -> r2=8'h02, carry unchanged.
